// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared constants, state/transform encodings and helpers for the SPART echo driver
package spart_pkg;

  // SPART register map as seen on ioaddr
  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    RX_RD,
    TX_WR,
    GAP
  } drv_state_e;

  typedef enum logic [1:0] {
    XF_NONE,
    XF_UPPER,
    XF_LOWER,
    XF_INVERT
  } xform_e;

  // Baud index 0..3 selects 4800 << idx; divisor truncates like the SPART expects
  function automatic logic [15:0] baud_div(input logic [1:0] idx, input int unsigned clk_freq);
    int unsigned baud;
    baud = 32'd4800 << idx;
    return 16'(clk_freq / (32'd16 * baud) - 32'd1);
  endfunction

  // Per-byte TX transform; non-letters pass through the case conversions untouched
  function automatic logic [7:0] apply_xform(input xform_e mode, input logic [7:0] b);
    logic [7:0] r;
    r = b;
    case (mode)
      XF_UPPER:  if (b >= 8'h61 && b <= 8'h7A) r = b - 8'h20;
      XF_LOWER:  if (b >= 8'h41 && b <= 8'h5A) r = b + 8'h20;
      XF_INVERT: r = ~b;
      default:   r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spart_drv_fifo.sv
// rtl/spart_drv_fifo.sv - byte FIFO buffering received bytes until the SPART can take them back
module spart_drv_fifo #(
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spart_echo_driver.sv
// rtl/spart_echo_driver.sv - SPART bus master: programs the baud divisor then echoes received bytes
module spart_echo_driver
  import spart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int DEPTH    = 8,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       br_cfg,
  input  logic [1:0]       xform,
  input  logic             rda,
  input  logic             tbr,
  output logic             iocs,
  output logic             iorw,
  output logic [1:0]       ioaddr,
  inout  wire  [7:0]       databus,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow,
  output logic             cfg_done
);

  drv_state_e state;
  drv_state_e ret_state;
  logic [1:0] br_q;
  logic [7:0] data_out;
  logic       rd_pend;
  logic [15:0] div;

  logic       fifo_push;
  logic       fifo_pop;
  logic [7:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;

  assign div = baud_div(br_q, CLK_FREQ);

  // Outputs are registered: an op launched from a state is on the bus for the
  // following cycle (spent in GAP), and GAP's own edge drops iocs for the settle cycle.
  assign databus = (iocs && !iorw) ? data_out : 8'bz;

  // Read data is captured on the edge that ends the bus read cycle
  assign fifo_push = (state == GAP) && rd_pend;
  assign fifo_pop  = (state == TX_WR);

  spart_drv_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (databus),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Bus sequencer: configuration writes, then echo loop with RX priority over TX
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CFG_LO;
      ret_state <= IDLE;
      br_q      <= br_cfg;
      cfg_done  <= 1'b0;
      overflow  <= 1'b0;
      iocs      <= 1'b0;
      iorw      <= 1'b1;
      ioaddr    <= ADDR_STAT;
      data_out  <= 8'h00;
      rd_pend   <= 1'b0;
    end else begin
      case (state)
        CFG_LO: begin
          iocs      <= 1'b1;
          iorw      <= 1'b0;
          ioaddr    <= ADDR_DBL;
          data_out  <= div[7:0];
          ret_state <= CFG_HI;
          state     <= GAP;
        end
        CFG_HI: begin
          iocs      <= 1'b1;
          iorw      <= 1'b0;
          ioaddr    <= ADDR_DBH;
          data_out  <= div[15:8];
          cfg_done  <= 1'b1;
          ret_state <= IDLE;
          state     <= GAP;
        end
        IDLE: begin
          if (br_cfg != br_q) begin
            br_q     <= br_cfg;
            cfg_done <= 1'b0;
            state    <= CFG_LO;
          end else if (rda) begin
            state <= RX_RD;
          end else if (tbr && !fifo_empty) begin
            state <= TX_WR;
          end
        end
        RX_RD: begin
          iocs      <= 1'b1;
          iorw      <= 1'b1;
          ioaddr    <= ADDR_BUF;
          rd_pend   <= 1'b1;
          ret_state <= IDLE;
          state     <= GAP;
        end
        TX_WR: begin
          iocs      <= 1'b1;
          iorw      <= 1'b0;
          ioaddr    <= ADDR_BUF;
          data_out  <= apply_xform(xform_e'(xform), fifo_head);
          ret_state <= IDLE;
          state     <= GAP;
        end
        GAP: begin
          iocs    <= 1'b0;
          iorw    <= 1'b1;
          ioaddr  <= ADDR_STAT;
          rd_pend <= 1'b0;
          if (rd_pend && fifo_full) overflow <= 1'b1;
          state   <= ret_state;
        end
        default: state <= CFG_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_echo_driver.sv
// tb/tb_spart_echo_driver.sv - self-checking bench for spart_echo_driver with a SPART-side model
module tb_spart_echo_driver;

  localparam int CLK_FREQ = 50_000_000;
  localparam int DEPTH    = 8;
  localparam int CNT_W    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       br_cfg = 2'b01;
  logic [1:0]       xform = 2'b00;
  logic             rda = 1'b0;
  logic             tbr = 1'b0;
  logic             iocs;
  logic             iorw;
  logic [1:0]       ioaddr;
  wire  [7:0]       databus;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;
  logic             cfg_done;

  logic [7:0] rx_head = 8'h00;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [9:0] cfg_log[$];
  bit         op_log[$];
  bit         pop_next = 1'b0;
  bit         prev_iocs = 1'b0;
  int         cyc = 0;
  int         rd_cyc = 0;
  int         wr_cyc = 0;
  int         gap_viol = 0;
  int         checks = 0;
  int         errors = 0;

  // SPART side: answers buffer reads with the head of its receive queue
  assign databus = (iocs && iorw && ioaddr == 2'b00) ? rx_head : 8'bz;

  spart_echo_driver #(.CLK_FREQ(CLK_FREQ), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .br_cfg     (br_cfg),
    .xform      (xform),
    .rda        (rda),
    .tbr        (tbr),
    .iocs       (iocs),
    .iorw       (iorw),
    .ioaddr     (ioaddr),
    .databus    (databus),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .cfg_done   (cfg_done)
  );

  always #5 clk = ~clk;

  // Bus monitor and SPART model, evaluated mid-cycle
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      rx_q.delete();
      pop_next = 1'b0;
    end else if (pop_next) begin
      if (rx_q.size() != 0) void'(rx_q.pop_front());
      pop_next = 1'b0;
    end
    if (iocs && prev_iocs) gap_viol = gap_viol + 1;
    if (iocs && iorw && ioaddr == 2'b00) begin
      rd_cyc = cyc;
      op_log.push_back(1'b0);
      pop_next = 1'b1;
    end
    if (iocs && !iorw) begin
      if (ioaddr == 2'b00) begin
        wr_cyc = cyc;
        tx_q.push_back(databus);
        op_log.push_back(1'b1);
      end else begin
        cfg_log.push_back({ioaddr, databus});
      end
    end
    prev_iocs = iocs;
    rda = (rx_q.size() != 0);
    rx_head = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  end

  function automatic logic [7:0] model_xform(input int mode, input logic [7:0] b);
    int v;
    v = int'(b);
    if (mode == 1 && v >= 97 && v <= 122) v = v - 32;
    else if (mode == 2 && v >= 65 && v <= 90) v = v + 32;
    else if (mode == 3) v = 255 - v;
    return 8'(v);
  endfunction

  function automatic int model_div(input int idx);
    int baud;
    baud = 4800 * (1 << idx);
    return CLK_FREQ / (16 * baud) - 1;
  endfunction

  function automatic logic [7:0] rand_byte();
    int sel;
    sel = $urandom_range(0, 3);
    if (sel == 0) return 8'($urandom_range(65, 90));
    if (sel == 1) return 8'($urandom_range(97, 122));
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cfg(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (cfg_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rx_drained(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (rx_q.size() == 0 && !pop_next) begin
        ok = 1'b1;
        break;
      end
    end
    step();
  endtask

  task automatic wait_tx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (tx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    int d;
    for (int b = 0; b < 4; b++) begin
      step();
      rst_n = 1'b0;
      br_cfg = 2'(b);
      tbr = 1'b0;
      step();
      checks++;
      if (iocs !== 1'b0 || iorw !== 1'b1 || ioaddr !== 2'b01) begin
        errors++;
        $display("FAIL reset_bus br=%0d: iocs=%b iorw=%b ioaddr=%b, want 0 1 01", b, iocs, iorw, ioaddr);
      end
      checks++;
      if (fifo_count !== '0 || overflow !== 1'b0 || cfg_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags br=%0d: count=%0d ovf=%b cfg_done=%b, want 0 0 0", b, fifo_count, overflow, cfg_done);
      end
      cfg_log.delete();
      gap_viol = 0;
      rst_n = 1'b1;
      wait_cfg(30, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL cfg_timeout br=%0d: cfg_done never rose", b);
      end
      step();
      d = model_div(b);
      checks++;
      if (cfg_log.size() != 2 || cfg_log[0] !== {2'b10, 8'(d)} || cfg_log[1] !== {2'b11, 8'(d >> 8)}) begin
        errors++;
        $display("FAIL cfg_writes br=%0d: got %0d writes first=%h second=%h, want 2 writes %h %h",
                 b, cfg_log.size(), (cfg_log.size() > 0) ? cfg_log[0] : 10'h0,
                 (cfg_log.size() > 1) ? cfg_log[1] : 10'h0, {2'b10, 8'(d)}, {2'b11, 8'(d >> 8)});
      end
      checks++;
      if (gap_viol != 0) begin
        errors++;
        $display("FAIL cfg_gap br=%0d: %0d back-to-back op cycles, want 0", b, gap_viol);
      end
    end
    // Leave the design configured at 9600 for the remaining scenarios
    step();
    rst_n = 1'b0;
    br_cfg = 2'b01;
    step();
    rst_n = 1'b1;
    wait_cfg(30, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cfg_timeout_final: cfg_done never rose");
    end
  endtask

  task automatic test_echo();
    bit ok;
    tx_q.delete();
    xform = 2'b01;
    tbr = 1'b1;
    rx_q.push_back(8'h61);
    wait_tx(1, 40, ok);
    checks++;
    if (!ok || tx_q[0] !== 8'h41) begin
      errors++;
      $display("FAIL echo_byte: got %h (seen=%0d), want 41", (tx_q.size() > 0) ? tx_q[0] : 8'h00, tx_q.size());
    end
    checks++;
    if (wr_cyc - rd_cyc != 3) begin
      errors++;
      $display("FAIL echo_latency: write %0d cycles after read, want 3", wr_cyc - rd_cyc);
    end
    step();
    step();
    checks++;
    if (fifo_count !== '0) begin
      errors++;
      $display("FAIL echo_count: fifo_count=%0d, want 0", fifo_count);
    end
  endtask

  task automatic test_random_echo();
    bit ok;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int mode;
    int n;
    tbr = 1'b1;
    for (int r = 0; r < 6; r++) begin
      mode = $urandom_range(0, 3);
      xform = 2'(mode);
      n = $urandom_range(1, DEPTH);
      exp_q.delete();
      tx_q.delete();
      for (int i = 0; i < n; i++) begin
        b = rand_byte();
        exp_q.push_back(model_xform(mode, b));
        rx_q.push_back(b);
      end
      wait_tx(n, 20 * n + 20, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand_timeout round=%0d: %0d of %0d bytes echoed", r, tx_q.size(), n);
      end
      for (int i = 0; i < n && i < tx_q.size(); i++) begin
        checks++;
        if (tx_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_byte round=%0d idx=%0d mode=%0d: got %h, want %h", r, i, mode, tx_q[i], exp_q[i]);
        end
      end
    end
    step();
    checks++;
    if (overflow !== 1'b0 || fifo_count !== '0) begin
      errors++;
      $display("FAIL rand_state: ovf=%b count=%0d, want 0 0", overflow, fifo_count);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int mode;
    tbr = 1'b0;
    mode = $urandom_range(0, 3);
    xform = 2'(mode);
    tx_q.delete();
    for (int i = 0; i < DEPTH + 2; i++) begin
      b = rand_byte();
      if (i < DEPTH) exp_q.push_back(model_xform(mode, b));
      rx_q.push_back(b);
    end
    wait_rx_drained(200, ok);
    checks++;
    if (!ok || fifo_count !== CNT_W'(DEPTH) || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_fill: drained=%0d count=%0d ovf=%b, want 1 %0d 1", ok, fifo_count, overflow, DEPTH);
    end
    tbr = 1'b1;
    wait_tx(DEPTH, 200, ok);
    repeat (10) step();
    checks++;
    if (tx_q.size() != DEPTH) begin
      errors++;
      $display("FAIL ovf_tx_count: %0d bytes written, want %0d", tx_q.size(), DEPTH);
    end
    for (int i = 0; i < DEPTH && i < tx_q.size(); i++) begin
      checks++;
      if (tx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ovf_byte idx=%0d: got %h, want %h", i, tx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (fifo_count !== '0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after: count=%0d ovf=%b, want 0 1", fifo_count, overflow);
    end
  endtask

  task automatic test_priority();
    bit ok;
    logic [7:0] bs[3];
    tbr = 1'b0;
    xform = 2'b00;
    for (int i = 0; i < 3; i++) bs[i] = rand_byte();
    rx_q.push_back(bs[0]);
    rx_q.push_back(bs[1]);
    wait_rx_drained(60, ok);
    tx_q.delete();
    op_log.delete();
    rx_q.push_back(bs[2]);
    step();
    tbr = 1'b1;
    wait_tx(3, 60, ok);
    checks++;
    if (op_log.size() == 0 || op_log[0] !== 1'b0) begin
      errors++;
      $display("FAIL prio_first_op: first op is_write=%0d (ops=%0d), want read", (op_log.size() > 0) ? op_log[0] : 1'b1, op_log.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tx_q.size() <= i || tx_q[i] !== bs[i]) begin
        errors++;
        $display("FAIL prio_byte idx=%0d: got %h, want %h", i, (tx_q.size() > i) ? tx_q[i] : 8'h00, bs[i]);
      end
    end
  endtask

  task automatic test_reprogram();
    bit ok;
    logic [7:0] bs[3];
    int d;
    int mode;
    tbr = 1'b0;
    mode = $urandom_range(0, 3);
    xform = 2'(mode);
    for (int i = 0; i < 3; i++) begin
      bs[i] = rand_byte();
      rx_q.push_back(bs[i]);
    end
    wait_rx_drained(60, ok);
    checks++;
    if (fifo_count !== CNT_W'(3)) begin
      errors++;
      $display("FAIL reprog_fill: count=%0d, want 3", fifo_count);
    end
    cfg_log.delete();
    tx_q.delete();
    br_cfg = 2'b11;
    step();
    checks++;
    if (cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL reprog_drop: cfg_done=%b, want 0", cfg_done);
    end
    wait_cfg(30, ok);
    step();
    d = model_div(3);
    checks++;
    if (!ok || cfg_log.size() != 2 || cfg_log[0] !== {2'b10, 8'(d)} || cfg_log[1] !== {2'b11, 8'(d >> 8)}) begin
      errors++;
      $display("FAIL reprog_writes: done=%0d writes=%0d first=%h, want 2 writes %h %h", ok, cfg_log.size(),
               (cfg_log.size() > 0) ? cfg_log[0] : 10'h0, {2'b10, 8'(d)}, {2'b11, 8'(d >> 8)});
    end
    checks++;
    if (fifo_count !== CNT_W'(3) || tx_q.size() != 0) begin
      errors++;
      $display("FAIL reprog_keep: count=%0d tx=%0d, want 3 0", fifo_count, tx_q.size());
    end
    tbr = 1'b1;
    wait_tx(3, 60, ok);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tx_q.size() <= i || tx_q[i] !== model_xform(mode, bs[i])) begin
        errors++;
        $display("FAIL reprog_byte idx=%0d: got %h, want %h", i, (tx_q.size() > i) ? tx_q[i] : 8'h00, model_xform(mode, bs[i]));
      end
    end
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    bit found;
    int d;
    tbr = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) rx_q.push_back(rand_byte());
    wait_rx_drained(200, ok);
    tbr = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (iocs && !iorw && ioaddr == 2'b00) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_find: no TX write seen within budget");
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (iocs !== 1'b0 || iorw !== 1'b1 || ioaddr !== 2'b01) begin
      errors++;
      $display("FAIL mid_bus: iocs=%b iorw=%b ioaddr=%b, want 0 1 01", iocs, iorw, ioaddr);
    end
    checks++;
    if (fifo_count !== '0 || overflow !== 1'b0 || cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_flags: count=%0d ovf=%b cfg_done=%b, want 0 0 0", fifo_count, overflow, cfg_done);
    end
    tbr = 1'b0;
    cfg_log.delete();
    rst_n = 1'b1;
    wait_cfg(30, ok);
    step();
    d = model_div(int'(br_cfg));
    checks++;
    if (!ok || cfg_log.size() == 0 || cfg_log[0] !== {2'b10, 8'(d)}) begin
      errors++;
      $display("FAIL mid_restart: done=%0d first=%h, want %h", ok, (cfg_log.size() > 0) ? cfg_log[0] : 10'h0, {2'b10, 8'(d)});
    end
  endtask

  initial begin
    test_reset();
    test_echo();
    test_random_echo();
    test_overflow();
    test_priority();
    test_reprogram();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
